// File: rtl/monitor_pkg.sv
// rtl/monitor_pkg.sv - shared mode type, bit indices and saturation helper for the monitor controller
package monitor_pkg;

    typedef struct packed {
        logic side;
        logic mono;
        logic cut;
        logic dim;
    } mode_t;

    localparam int MODE_DIM  = 0;
    localparam int MODE_CUT  = 1;
    localparam int MODE_MONO = 2;
    localparam int MODE_SIDE = 3;

    // Difference of two sign-extended samples, clamped to a signed range of the given width.
    function automatic logic signed [63:0] sat_sub(
        input logic signed [63:0] a,
        input logic signed [63:0] b,
        input int                 width
    );
        logic signed [63:0] diff;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        diff = a - b;
        hi   = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo   = -hi - 64'sd1;
        if (diff > hi) begin
            return hi;
        end
        if (diff < lo) begin
            return lo;
        end
        return diff;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - 2-FF synchroniser, hold-time debouncer and press pulse for one button
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_btn,
    output logic o_rise
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          level_q;
    logic          level_d;
    logic          rise_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Count only while the synchronised level disagrees with the accepted level.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        if (sync_q[1] == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            level_d = sync_q[1];
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], i_btn};
            level_q <= level_d;
            cnt_q   <= cnt_d;
            rise_q  <= level_d & ~level_q;
        end
    end

    assign o_rise = rise_q;

endmodule

// File: rtl/monitor_controller_ramp.sv
// rtl/monitor_controller_ramp.sv - stereo monitor matrix with click-free ramped dim/cut gain
module monitor_controller_ramp
    import monitor_pkg::*;
#(
    parameter int DATA_WIDTH      = 24,
    parameter int GAIN_BITS       = 8,
    parameter int DIM_SHIFT       = 2,
    parameter int RAMP_STEP       = 4,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                         i_clock,
    input  logic                         i_reset,
    input  logic signed [DATA_WIDTH-1:0] i_data_left,
    input  logic signed [DATA_WIDTH-1:0] i_data_right,
    input  logic                         i_data_valid,
    input  logic                         i_btnu,
    input  logic                         i_btnd,
    input  logic                         i_btnl,
    input  logic                         i_btnr,
    output logic signed [DATA_WIDTH-1:0] o_data_left,
    output logic signed [DATA_WIDTH-1:0] o_data_right,
    output logic                         o_data_valid,
    output logic [3:0]                   o_mode,
    output logic                         o_ramp_busy
);
    localparam int W  = DATA_WIDTH;
    localparam int GW = GAIN_BITS + 1;
    localparam int PW = DATA_WIDTH + GAIN_BITS + 1;
    localparam logic [GW-1:0] UNITY    = GW'(1) << GAIN_BITS;
    localparam logic [GW-1:0] DIM_GAIN = UNITY >> DIM_SHIFT;
    localparam logic [GW-1:0] STEP     = GW'(RAMP_STEP);

    logic [3:0] btn_raw;
    logic [3:0] btn_rise;

    assign btn_raw = {i_btnr, i_btnl, i_btnd, i_btnu};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_btn
            button_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .i_clock(i_clock),
                .i_reset(i_reset),
                .i_btn  (btn_raw[gi]),
                .o_rise (btn_rise[gi])
            );
        end
    endgenerate

    function automatic logic [GW-1:0] target_of(input mode_t m);
        if (m.cut) begin
            return '0;
        end
        if (m.dim) begin
            return DIM_GAIN;
        end
        return UNITY;
    endfunction

    mode_t                mode_q;
    mode_t                mode_d;
    logic [GW-1:0]        gain_q;
    logic [GW-1:0]        gain_d;
    logic [GW-1:0]        tgt_q;
    logic                 busy_q;
    logic                 busy_d;
    logic                 s1_valid_q;
    logic signed [W-1:0]  s1_l_q;
    logic signed [W-1:0]  s1_r_q;
    logic [GW-1:0]        s1_gain_q;
    logic                 out_valid_q;
    logic signed [W-1:0]  out_l_q;
    logic signed [W-1:0]  out_r_q;

    logic signed [63:0]   l_ext;
    logic signed [63:0]   r_ext;
    logic signed [W:0]    sum;
    logic signed [W-1:0]  mat_l;
    logic signed [W-1:0]  mat_r;
    logic signed [PW-1:0] prod_l;
    logic signed [PW-1:0] prod_r;

    assign mode_d = mode_q ^ btn_rise;

    // Matrix uses the registered mode, so a toggle landing with a sample affects the next one.
    always_comb begin
        l_ext = {{(64-W){i_data_left[W-1]}}, i_data_left};
        r_ext = {{(64-W){i_data_right[W-1]}}, i_data_right};
        sum   = {i_data_left[W-1], i_data_left} + {i_data_right[W-1], i_data_right};
        mat_l = i_data_left;
        mat_r = i_data_right;
        if (mode_q.side) begin
            mat_l = W'(sat_sub(l_ext, r_ext, W));
            mat_r = mat_l;
        end else if (mode_q.mono) begin
            mat_l = W'(sum >>> 1);
            mat_r = mat_l;
        end
    end

    always_comb begin
        tgt_q  = target_of(mode_q);
        gain_d = gain_q;
        if (i_data_valid) begin
            if (gain_q > tgt_q) begin
                gain_d = ((gain_q - tgt_q) > STEP) ? (gain_q - STEP) : tgt_q;
            end else if (gain_q < tgt_q) begin
                gain_d = ((tgt_q - gain_q) > STEP) ? (gain_q + STEP) : tgt_q;
            end
        end
        busy_d = (gain_d != target_of(mode_d));
    end

    always_comb begin
        prod_l = $signed({{(GAIN_BITS+1){s1_l_q[W-1]}}, s1_l_q}) * $signed({{W{1'b0}}, s1_gain_q});
        prod_r = $signed({{(GAIN_BITS+1){s1_r_q[W-1]}}, s1_r_q}) * $signed({{W{1'b0}}, s1_gain_q});
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            mode_q      <= '0;
            gain_q      <= UNITY;
            busy_q      <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_l_q      <= '0;
            s1_r_q      <= '0;
            s1_gain_q   <= UNITY;
            out_valid_q <= 1'b0;
            out_l_q     <= '0;
            out_r_q     <= '0;
        end else begin
            mode_q      <= mode_d;
            gain_q      <= gain_d;
            busy_q      <= busy_d;
            s1_valid_q  <= i_data_valid;
            out_valid_q <= s1_valid_q;
            if (i_data_valid) begin
                s1_l_q    <= mat_l;
                s1_r_q    <= mat_r;
                s1_gain_q <= gain_q;
            end
            if (s1_valid_q) begin
                out_l_q <= W'(prod_l >>> GAIN_BITS);
                out_r_q <= W'(prod_r >>> GAIN_BITS);
            end
        end
    end

    assign o_data_left  = out_l_q;
    assign o_data_right = out_r_q;
    assign o_data_valid = out_valid_q;
    assign o_mode       = mode_q;
    assign o_ramp_busy  = busy_q;

endmodule
